// File: rtl/lut_sweep_eval.sv
// Sweeps an N-input truth table over x = 0..2^N-1, one registered (x, F) per enabled cycle, collecting results.
// Optional comparator against i_exp_tt is built when LUT_SWEEP_CHECK_EN is defined; otherwise mismatch outputs are 0.
module lut_sweep_eval #(
   parameter int N = 4,
   parameter logic [(2**N)-1:0] TT_INIT = 16'h9FF8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic              i_step_en,
   input  logic              i_tt_load,
   input  logic [(2**N)-1:0] i_tt_in,
   input  logic [(2**N)-1:0] i_exp_tt,
   output logic              o_busy,
   output logic              o_valid,
   output logic [N-1:0]      o_x_out,
   output logic              o_f_out,
   output logic              o_done,
   output logic [N:0]        o_ones_count,
   output logic [(2**N)-1:0] o_result_vec,
   output logic              o_mismatch,
   output logic [N-1:0]      o_first_bad
);
   localparam int W = 2**N;

   typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [W-1:0]   r_tt;
   logic [N-1:0]   r_idx;
   logic [N-1:0]   r_x;
   logic           r_f;
   logic           r_valid;
   logic [N:0]     r_ones;
   logic [W-1:0]   r_res;
   logic           w_f;
   logic           w_eval;
   logic           w_last;
   logic           w_accept;

   assign w_f      = r_tt[r_idx];
   assign w_eval   = (r_state == S_SWEEP) && i_step_en;
   assign w_last   = (r_idx == {N{1'b1}});
   assign w_accept = (r_state == S_IDLE) && i_start;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_state_nxt = S_SWEEP;
         S_SWEEP: if (w_eval && w_last) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_tt    <= TT_INIT;
         r_idx   <= '0;
         r_x     <= '0;
         r_f     <= 1'b0;
         r_valid <= 1'b0;
         r_ones  <= '0;
         r_res   <= '0;
      end else begin
         r_valid <= w_eval;
         // a load coinciding with start lands before the first evaluation edge
         if ((r_state == S_IDLE) && i_tt_load) begin
            r_tt <= i_tt_in;
         end
         if (w_accept) begin
            r_idx  <= '0;
            r_ones <= '0;
            r_res  <= '0;
         end
         if (w_eval) begin
            r_x        <= r_idx;
            r_f        <= w_f;
            r_res[r_idx] <= w_f;
            r_ones     <= r_ones + (N+1)'(w_f);
            r_idx      <= r_idx + N'(1);
         end
      end
   end

`ifdef LUT_SWEEP_CHECK_EN
   logic         r_mis;
   logic [N-1:0] r_bad;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_mis <= 1'b0;
         r_bad <= '0;
      end else if (w_accept) begin
         r_mis <= 1'b0;
         r_bad <= '0;
      end else if (w_eval && !r_mis && (w_f != i_exp_tt[r_idx])) begin
         r_mis <= 1'b1;
         r_bad <= r_idx;
      end
   end

   assign o_mismatch  = r_mis;
   assign o_first_bad = r_bad;
`else
   logic w_unused_exp;
   assign w_unused_exp = ^i_exp_tt;
   assign o_mismatch   = 1'b0;
   assign o_first_bad  = '0;
`endif

   assign o_busy       = (r_state == S_SWEEP);
   assign o_done       = (r_state == S_DONE);
   assign o_valid      = r_valid;
   assign o_x_out      = r_x;
   assign o_f_out      = r_f;
   assign o_ones_count = r_ones;
   assign o_result_vec = r_res;
endmodule

// File: tb/tb_lut_sweep_eval.sv
// Scoreboard bench for lut_sweep_eval: expected (x, F) pairs are queued at start and popped on each valid output.
module tb_lut_sweep_eval;
   localparam int N = 4;
   localparam int W = 16;

   typedef struct packed {
      logic [N-1:0] x;
      logic         f;
   } ev_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          step_en = 1'b0;
   logic          tt_load = 1'b0;
   logic [W-1:0]  tt_in = '0;
   logic [W-1:0]  exp_tt = '0;
   logic          o_busy, o_valid, o_f_out, o_done, o_mismatch;
   logic [N-1:0]  o_x_out, o_first_bad;
   logic [N:0]    o_ones_count;
   logic [W-1:0]  o_result_vec;

   int            n_checks = 0;
   int            n_fail = 0;
   ev_t           sb_q[$];
   ev_t           mon_e;
   logic [W-1:0]  tb_tt = 16'h9FF8;

   lut_sweep_eval #(.N(N), .TT_INIT(16'h9FF8)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_step_en(step_en),
      .i_tt_load(tt_load), .i_tt_in(tt_in), .i_exp_tt(exp_tt),
      .o_busy(o_busy), .o_valid(o_valid), .o_x_out(o_x_out), .o_f_out(o_f_out),
      .o_done(o_done), .o_ones_count(o_ones_count), .o_result_vec(o_result_vec),
      .o_mismatch(o_mismatch), .o_first_bad(o_first_bad)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && o_valid) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected_valid", 32'(sb_q.size()), 1);
         end else begin
            mon_e = sb_q.pop_front();
            chk("x_out", 32'(o_x_out), 32'(mon_e.x));
            chk("f_out", 32'(o_f_out), 32'(mon_e.f));
         end
      end
   end

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, 32'(o_busy), 0);
      chk({tag, "_valid"}, 32'(o_valid), 0);
      chk({tag, "_done"}, 32'(o_done), 0);
      chk({tag, "_x"}, 32'(o_x_out), 0);
      chk({tag, "_f"}, 32'(o_f_out), 0);
      chk({tag, "_ones"}, 32'(o_ones_count), 0);
      chk({tag, "_res"}, 32'(o_result_vec), 0);
      chk({tag, "_mis"}, 32'(o_mismatch), 0);
      chk({tag, "_bad"}, 32'(o_first_bad), 0);
   endtask

   task automatic push_table(input logic [W-1:0] t);
      ev_t e;
      for (int i = 0; i < W; i++) begin
         e.x = N'(i);
         e.f = t[i];
         sb_q.push_back(e);
      end
   endtask

   // One full sweep; optional simultaneous load, a pause after x=4, and ignored start/load pokes at x=7.
   task automatic run_sweep(input string name, input bit do_load, input logic [W-1:0] ld_val,
                            input int plen, input bit poke, input logic [W-1:0] exp_v);
      logic [W-1:0] model;
      logic [W-1:0] diff;
      logic         exp_mis;
      logic [N-1:0] exp_bad;
      int           ones;
      int           cyc;
      int           low_left;
      bit           paused;
      bit           poked;
      @(posedge clk); #1;
      if (do_load) begin
         tt_load = 1'b1;
         tt_in   = ld_val;
         tb_tt   = ld_val;
      end
      exp_tt  = exp_v;
      start   = 1'b1;
      step_en = 1'b1;
      model   = tb_tt;
      ones    = 0;
      for (int i = 0; i < W; i++) ones += int'(model[i]);
      push_table(model);
      diff = model ^ exp_v;
      exp_bad = '0;
`ifdef LUT_SWEEP_CHECK_EN
      exp_mis = |diff;
      for (int i = W - 1; i >= 0; i--) if (diff[i]) exp_bad = N'(i);
`else
      exp_mis = 1'b0;
`endif
      @(posedge clk); #1;
      start   = 1'b0;
      tt_load = 1'b0;
      chk({name, "_busy_after_start"}, 32'(o_busy), 1);
      cyc = 0; low_left = 0; paused = 0; poked = 0;
      while (!o_done && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
         start   = 1'b0;
         tt_load = 1'b0;
         if (low_left > 0) begin
            chk({name, "_gap_valid"}, 32'(o_valid), 0);
            chk({name, "_gap_x"}, 32'(o_x_out), 4);
            low_left--;
            if (low_left == 0) step_en = 1'b1;
         end else if (plen > 0 && !paused && o_valid && o_x_out == 4'd4) begin
            step_en  = 1'b0;
            low_left = plen;
            paused   = 1;
         end
         if (poke && !poked && o_valid && o_x_out == 4'd7) begin
            start   = 1'b1;
            tt_load = 1'b1;
            tt_in   = '0;
            poked   = 1;
         end
      end
      chk({name, "_done_cycle"}, 32'(cyc), 32'(W + plen));
      chk({name, "_busy_at_done"}, 32'(o_busy), 0);
      chk({name, "_result_vec"}, 32'(o_result_vec), 32'(model));
      chk({name, "_ones_count"}, 32'(o_ones_count), 32'(ones));
      chk({name, "_mismatch"}, 32'(o_mismatch), 32'(exp_mis));
      chk({name, "_first_bad"}, 32'(o_first_bad), 32'(exp_bad));
      @(posedge clk); #1;
      chk({name, "_done_pulse"}, 32'(o_done), 0);
      chk({name, "_idle_busy"}, 32'(o_busy), 0);
      chk({name, "_hold_result"}, 32'(o_result_vec), 32'(model));
      chk({name, "_sb_drained"}, 32'(sb_q.size()), 0);
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      rst_n = 1'b1;

      run_sweep("dflt", 0, '0, 0, 0, 16'h9FF8);
      run_sweep("ld0", 1, 16'h0000, 0, 0, 16'h0000);

      @(posedge clk); #1;
      tt_load = 1'b1;
      tt_in   = 16'hFFFF;
      tb_tt   = 16'hFFFF;
      @(posedge clk); #1;
      tt_load = 1'b0;
      run_sweep("ldF", 0, '0, 0, 0, 16'hFFFF);

      // Abort a sweep of the 0xFFFF table at x=9; reset must restore the power-up table.
      @(posedge clk); #1;
      start   = 1'b1;
      step_en = 1'b1;
      push_table(tb_tt);
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (!(o_valid && o_x_out == 4'd9) && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("rst_reach_x9", 32'(o_x_out), 9);
      rst_n = 1'b0;
      #1;
      chk_zero("rst_mid");
      sb_q.delete();
      tb_tt = 16'h9FF8;
      @(posedge clk); #1;
      rst_n = 1'b1;

      run_sweep("after_rst", 0, '0, 0, 0, 16'h9FF0);
      run_sweep("pause", 0, '0, 3, 0, 16'h9FF8);
      run_sweep("ignored", 0, '0, 0, 1, 16'h9FF8);
      run_sweep("post_ignored", 0, '0, 0, 0, 16'h1234);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/lut_sweep_eval.md
# lut_sweep_eval

Parametrised, clocked evaluator that runs an N-input Boolean function, held as a 2^N-entry truth table, over all input combinations in ascending order. It produces one registered (x, F) pair per enabled cycle, builds the full result vector and counts the ones. It sits beside the team's gate-level combinational exercises as the reusable hardware replacement for a hand-written exhaustive testbench sweep.

## Interface
- `N`, 4: input width; legal range 1..8.
- `TT_INIT`, 16'h9FF8: truth table loaded at reset. Bit i is F(x=i). Width is 2^N.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `start`  in  1: begin a sweep. Sampled in IDLE only.
- `step_en`  in  1: advance the sweep this cycle. Low pauses the sweep.
- `tt_load`  in  1: write `tt_in` into the table register. Honoured in IDLE only.
- `tt_in`  in  2^N: new truth table.
- `exp_tt`  in  2^N: expected result vector. Used only with `LUT_SWEEP_CHECK_EN`.
- `busy`  out  1: high in SWEEP.
- `valid`  out  1: `x_out` and `f_out` hold a fresh evaluation.
- `x_out`  out  N: input vector just evaluated.
- `f_out`  out  1: `tt_reg[x_out]`.
- `done`  out  1: single-cycle pulse at the end of a sweep.
- `ones_count`  out  N+1: number of indices with F=1.
- `result_vec`  out  2^N: collected F values.
- `mismatch`  out  1: the sweep result differs from `exp_tt`.
- `first_bad`  out  N: lowest mismatching index.

## Operation
- States: IDLE, SWEEP, DONE.
- **IDLE → SWEEP** on `start`=1.
  - On that edge: `idx`←0, `ones_count`←0, `result_vec`←0, `mismatch`←0, `first_bad`←0.
- **In SWEEP, each edge with `step_en`=1:**
  - `x_out`←`idx`, `f_out`←`tt_reg[idx]`, `result_vec[idx]`←`tt_reg[idx]`, `valid`←1.
  - `ones_count` increments by `tt_reg[idx]`.
  - `idx`←`idx`+1.
- **In SWEEP, each edge with `step_en`=0:** `valid`←0. All other state holds.
- **SWEEP → DONE** on the edge that evaluates `idx`=2^N−1. `idx` does not wrap and is not reused.
- **DONE → IDLE** unconditionally after one cycle. `done`=1 exactly during DONE.
- Results hold until the next accepted `start`.
- `start` is ignored in SWEEP and DONE. It is not queued.
- `tt_load` is ignored in SWEEP and DONE.
- `tt_load` and `start` in the same IDLE cycle: the table is written on that edge, and the sweep uses the new table from its first evaluation.
- `ones_count` never overflows: the maximum is 2^N, which fits in N+1 bits.
- **Reset (any time, including mid-sweep):**
  - state IDLE, `tt_reg`←`TT_INIT`.
  - `busy`, `valid`, `done`, `f_out`, `mismatch` all 0.
  - `x_out`, `first_bad`, `ones_count`, `result_vec` all 0.

## Timing
- Start accepted at edge E0. Evaluations happen at E1..E(2^N) when `step_en` is held high.
- Each evaluation is visible on the outputs in the cycle after its edge.
- `busy` is high from after E0 until after E(2^N).
- `done` is high in the cycle after E(2^N).
- Each low cycle of `step_en` adds one cycle to both `busy` and the time to `done`.
- `mismatch` and `first_bad` are valid when `done`=1.
- Idle-to-idle minimum is 2^N+2 cycles.

## Configuration
- `LUT_SWEEP_CHECK_EN` defined:
  - Each evaluation compares `tt_reg[idx]` with `exp_tt[idx]`.
  - On the first difference, `mismatch` is set and `first_bad`←`idx`.
  - Later differences do not change `first_bad`.
  - `exp_tt` must stay stable from `start` until `done`.
- `LUT_SWEEP_CHECK_EN` undefined:
  - The comparator is not built.
  - `mismatch` and `first_bad` are tied to 0.
  - `exp_tt` is unused.

## Test plan
- **Default table:** reset, then `start` with `step_en`=1 throughout → 16 `valid` cycles with `x_out` 0..15; `f_out` sequence 0,0,0,1,1,1,1,1,1,1,1,1,1,0,0,1; `result_vec`=16'h9FF8; `ones_count`=11; `done` high for one cycle after E16.
- **Load and start together:** `tt_load`=1 with `tt_in`=16'h0000, plus `start` in the same cycle → `ones_count`=0, `result_vec`=0. Then load 16'hFFFF and sweep → `ones_count`=16 (5'b10000).
- **Pause:** `step_en` low for 3 cycles after the 5th evaluation → `x_out` holds 4, `valid`=0 during the gap, `done` arrives 3 cycles late, results identical to the default run.
- **Ignored requests:** `start` and `tt_load` pulsed at `x_out`=7 → no restart, table unchanged, `result_vec`=16'h9FF8.
- **Reset mid-sweep:** `rst_n` low at `x_out`=9 → all outputs 0 immediately, table back to 16'h9FF8; a fresh `start` yields the default results.
- **Check enabled:** `exp_tt`=16'h9FF0 → `mismatch`=1, `first_bad`=3 at `done`. With `exp_tt`=16'h9FF8 → `mismatch`=0. With the macro undefined → `mismatch`=0 for any `exp_tt`.
